// File: rtl/dm_store_buffer.sv
// MEM-stage data-memory controller: posted-store FIFO draining to a shared single-port SRAM,
// loads ordered against buffered stores. Define STB_FWD_EN to forward full-word buffered stores.
module dm_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dm_addr,
  input  logic [3:0]        dm_w_en,
  input  logic              dm_rd_en,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_read_data,
  output logic              dm_stall,
  output logic              sb_empty,
  output logic              sram_en,
  input  logic              sram_gnt,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLdRd   = 2'd1;
  localparam logic [1:0] StLdData = 2'd2;

  logic [ADDR_W-1:0] waddr_q [DEPTH];
  logic [3:0]        be_q    [DEPTH];
  logic [31:0]       wdata_q [DEPTH];

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      state_q, state_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [ADDR_W-1:0] word_addr;
  logic              is_store, is_load, full, push, pop;
  logic              hit, fwd_hit, load_rd, load_stall, drain_req;

  logic unused_addr;
  assign unused_addr = ^{dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  assign word_addr = dm_addr[ADDR_W+1:2];
  assign is_store  = |dm_w_en;
  assign is_load   = dm_rd_en & ~is_store;
  assign full      = (count_q == CntW'(DEPTH));
  assign push      = is_store & ~full;
  assign sb_empty  = (count_q == '0);

`ifdef STB_FWD_EN
  logic        youngest_full;
  logic [31:0] fwd_data;
`endif

  // Scan occupied slots oldest to youngest; later matches overwrite, leaving the youngest.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx = '0;
    hit = 1'b0;
`ifdef STB_FWD_EN
    youngest_full = 1'b0;
    fwd_data      = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (waddr_q[idx] == word_addr)) begin
        hit = 1'b1;
`ifdef STB_FWD_EN
        youngest_full = (be_q[idx] == 4'b1111);
        fwd_data      = wdata_q[idx];
`endif
      end
    end
  end

`ifdef STB_FWD_EN
  assign fwd_hit = hit & youngest_full;
`else
  assign fwd_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    dm_read_data = rdata_q;
    load_rd      = 1'b0;
    load_stall   = 1'b0;
    case (state_q)
      StLdData: begin
        dm_read_data = sram_rdata;
        rdata_d      = sram_rdata;
        state_d      = StIdle;
      end
      default: begin
        // StIdle and the reserved StLdRd encoding behave identically.
        state_d = StIdle;
        if (is_load) begin
          if (fwd_hit) begin
`ifdef STB_FWD_EN
            dm_read_data = fwd_data;
            rdata_d      = fwd_data;
`endif
          end else if (hit) begin
            load_stall = 1'b1;
          end else begin
            load_rd    = 1'b1;
            load_stall = 1'b1;
            if (sram_gnt) begin
              state_d = StLdData;
            end
          end
        end
      end
    endcase
  end

  // A hitting load leaves load_rd low, so the drain keeps running until the hit clears.
  assign drain_req = ~sb_empty & ~load_rd;
  assign pop       = drain_req & sram_gnt;

  assign sram_en    = load_rd | drain_req;
  assign sram_we    = drain_req ? be_q[rptr_q] : 4'b0000;
  assign sram_addr  = load_rd ? word_addr : waddr_q[rptr_q];
  assign sram_wdata = wdata_q[rptr_q];
  assign dm_stall   = (is_store & full) | load_stall;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PtrW'(1) : rptr_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wptr_q] <= word_addr;
      be_q[wptr_q]    <= dm_w_en;
      wdata_q[wptr_q] <= dm_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= StIdle;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Data-memory controller on the CPU's MEM-stage data port, directly downstream of the pipeline.
- Takes load/store requests (byte-lane write enables, byte address, store data) and returns load data plus a stall.
- Stores post into a DEPTH-entry FIFO store buffer and drain to a shared, synchronous single-port SRAM when the port is granted.
- Loads read the SRAM with one-cycle latency and are ordered against buffered stores.

Parameters:
DEPTH, 4, store-buffer entries; power of 2, >=2
ADDR_W, 14, SRAM word-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
dm_addr  in  32  byte address from EX/MEM ALU output
dm_w_en  in  4  byte-lane store enables; nonzero = store
dm_rd_en  in  1  load request
dm_wdata  in  32  store data, lane-aligned
dm_read_data  out  32  load data to MEM/WB
dm_stall  out  1  freezes pipeline; CPU holds request stable while 1
sb_empty  out  1  buffer empty (fence/idle indication)
sram_en  out  1  SRAM access request
sram_gnt  in  1  arbiter grant; access occurs only when sram_en && sram_gnt
sram_we  out  4  byte write enables; 0 = read
sram_addr  out  ADDR_W  word address
sram_wdata  out  32  write data
sram_rdata  in  32  read data, valid cycle after granted read

Behaviour:
- Word address = dm_addr[ADDR_W+1:2]; dm_addr[1:0] ignored; lanes carried by dm_w_en.
- Reset (rst=0, async): FIFO emptied, pointers/count 0, FSM IDLE, read-data register 0. Outputs: dm_stall=0, dm_read_data=0, sb_empty=1, sram_en=0, sram_we=0. Pending stores are discarded.
- dm_w_en!=0 with dm_rd_en=1: treated as a store; load ignored.
- Store:
  - count<DEPTH: push {waddr, be, wdata} at the clock edge; dm_stall=0.
  - count==DEPTH: dm_stall=1; no push. Push occurs in the first cycle count<DEPTH at cycle start; no same-cycle push-on-pop bypass.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, LD_RD, LD_DATA:
  - IDLE, load, no buffer entry with equal waddr: sram_en=1, sram_we=0, sram_addr=load waddr, dm_stall=1. On gnt -> LD_DATA; without gnt, stay in IDLE.
  - IDLE, load, buffer hit: dm_stall=1. Drain continues until no matching entry remains, then the read is issued as above.
  - LD_DATA: dm_read_data=sram_rdata (combinational); capture into read-data register; dm_stall=0 -> IDLE.
  - All other cycles: dm_read_data = read-data register.
  - LD_RD reserved; unreachable; decodes to IDLE.
- Drain:
  - When buffer nonempty and no load read is requested this cycle: sram_en=1, sram_we=head.be, sram_addr=head.waddr, sram_wdata=head.wdata.
  - Pop on gnt.
  - Load read has priority over drain only when the load has no buffer hit; otherwise drain wins. Drain is also allowed in the LD_DATA cycle.
- sram_en never asserted with we=0 except for a load read. One SRAM op per cycle.
- Store in the same cycle as pop: count unchanged, both pointers advance.
- Stores drain strictly in order; same-address stores are never merged.

Optional Feature:
STB_FWD_EN:
- Defined: on a load in IDLE, the youngest matching entry with be==4'b1111 forwards its wdata combinationally on dm_read_data and into the read-data register. dm_stall=0, no SRAM read, FSM stays IDLE.
- Youngest match partial (be!=1111): wait for drain as in the base behaviour.
- Undefined: any match waits for drain; no forwarding logic is synthesized.

Test Plan:
- Reset: drive rst=0 mid-drain with 3 entries -> dm_stall=0, dm_read_data=0, sram_en=0, sb_empty=1. After release, no pending write issues.
- Store 0x0000_1000 data 0xDEADBEEF be=1111, gnt=1 -> next cycle sram_en=1, sram_we=1111, sram_addr=0x400, sram_wdata=0xDEADBEEF. sb_empty=1 the cycle after.
- gnt=0, five back-to-back stores (DEPTH=4) -> four accepted, fifth holds dm_stall=1. Raise gnt -> one pop, fifth store pushes next cycle. Drains in issue order.
- Load 0x0000_0040 (no hit), SRAM word 0x12345678, gnt=1 -> dm_stall=1 for one cycle, then dm_read_data=0x12345678 with dm_stall=0. Value held afterwards.
- Store 0x2000 be=0011 data 0x0000AAAA, gnt=0, then load 0x2000 -> stall held. Raise gnt -> write, then read issued; returns merged SRAM word.
- STB_FWD_EN: store 0x3000 be=1111 0xCAFEF00D, gnt=0, then load 0x3000 -> dm_read_data=0xCAFEF00D, dm_stall=0 that cycle. Partial be repeats the no-forward wait.
